// File: rtl/inst_loader.sv
// Instruction-memory loader: parses a LEN/DATA/CSUM byte frame, writes 32-bit words
// sequentially, and holds the CPU in reset until the frame checksum verifies.
module inst_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t              state, state_nxt;
    logic [1:0]          byte_cnt;
    logic [31:0]         len_q;
    logic [23:0]         word_q;
    logic [7:0]          csum_q;
    logic                xfer;
    logic                start;
    logic                last_byte;
    logic                last_word;
    logic                len_too_big;
    logic [31:0]         len_full;
    logic [ADDR_WIDTH:0] wl_inc;

    assign xfer        = byte_valid_i && byte_ready_o;
    assign start       = load_start_i && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign last_byte   = (byte_cnt == 2'd3);
    assign len_full    = {byte_i, len_q[31:8]};
    assign len_too_big = {1'b0, len_full} > MAX_WORDS;
    assign wl_inc      = words_loaded_o + 1'b1;
    assign last_word   = (32'(wl_inc) == len_q);

    always_comb begin
        state_nxt    = state;
        byte_ready_o = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start_i) state_nxt = S_LEN;
            end
            S_LEN: begin
                byte_ready_o = 1'b1;
                if (xfer && last_byte) begin
                    if (len_too_big)          state_nxt = S_ERR;
                    else if (len_full == '0)  state_nxt = S_CSUM;
                    else                      state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready_o = 1'b1;
                if (xfer && last_byte && last_word) state_nxt = S_CSUM;
            end
            S_CSUM: begin
                byte_ready_o = 1'b1;
                if (xfer) state_nxt = (byte_i == csum_q) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            byte_cnt       <= '0;
            len_q          <= '0;
            word_q         <= '0;
            csum_q         <= '0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            cpu_hold_o     <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            words_loaded_o <= '0;
        end else begin
            state    <= state_nxt;
            mem_we_o <= 1'b0;
            if (start) begin
                cpu_hold_o     <= 1'b1;
                busy_o         <= 1'b1;
                done_o         <= 1'b0;
                err_o          <= 1'b0;
                words_loaded_o <= '0;
                csum_q         <= '0;
                byte_cnt       <= '0;
                len_q          <= '0;
            end
            if (xfer) byte_cnt <= byte_cnt + 2'd1;
            case (state)
                S_LEN: begin
                    if (xfer) len_q <= len_full;
                    if (xfer && last_byte && len_too_big) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ byte_i;
                        case (byte_cnt)
                            2'd0: word_q[7:0]   <= byte_i;
                            2'd1: word_q[15:8]  <= byte_i;
                            2'd2: word_q[23:16] <= byte_i;
                            default: begin
                                // Word address is simply the count of words already written.
                                mem_we_o       <= 1'b1;
                                mem_addr_o     <= words_loaded_o[ADDR_WIDTH-1:0];
                                mem_wdata_o    <= {byte_i, word_q};
                                words_loaded_o <= wl_inc;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        busy_o <= 1'b0;
                        if (byte_i == csum_q) begin
                            done_o     <= 1'b1;
                            cpu_hold_o <= 1'b0;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded bench for inst_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares address, data and write cycle.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_hold_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [12:0] words_loaded_o;

    inst_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load_start_i(load_start_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          at_cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fw[$];
    int          cyc = 0;
    int          last_hs;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_we_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr_o, mem_wdata_o}, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr_o, e.addr);
                chk("wr_data", mem_wdata_o, e.data);
                chk("wr_cycle", cyc, e.at_cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse);
        int t = 0;
        if (gap) begin
            byte_valid_i = 1'b0;
            @(negedge clk);
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        load_start_i = pulse;
        while (!byte_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            chk("ready_timeout", 0, 1);
            byte_valid_i = 1'b0;
            load_start_i = 1'b0;
            return;
        end
        last_hs = cyc + 1;
        @(negedge clk);
        byte_valid_i = 1'b0;
        load_start_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start_i = 1'b1;
        @(negedge clk);
        load_start_i = 1'b0;
    endtask

    // Reference: N > 4096 fails after LEN; otherwise N words at addresses 0..N-1,
    // success iff the CSUM byte equals the XOR of all data bytes.
    task automatic run_frame(input logic [31:0] n, input bit ovr, input logic [7:0] ovr_val,
                             input bit gaps, input int pulse_at);
        logic [7:0]  cs;
        logic [7:0]  sent;
        logic [31:0] wd;
        int          bi;
        bit          ok;
        cs = 8'h00;
        bi = 0;
        pulse_start();
        chk("start_status", {busy_o, cpu_hold_o, done_o, err_o, byte_ready_o}, 5'b11001);
        chk("start_words", words_loaded_o, 0);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps, 1'b0);
        if (n > 32'd4096) begin
            chk("len_err_status", {busy_o, cpu_hold_o, done_o, err_o, byte_ready_o}, 5'b01010);
            chk("len_err_words", words_loaded_o, 0);
            return;
        end
        for (int w = 0; w < int'(n); w++) begin
            wd = fw[w];
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ wd[8*b +: 8];
                send_byte(wd[8*b +: 8], gaps, bi == pulse_at);
                bi++;
            end
            exp_q.push_back('{addr: 12'(w), data: wd, at_cyc: last_hs});
        end
        sent = ovr ? ovr_val : cs;
        ok   = (sent == cs);
        send_byte(sent, gaps, 1'b0);
        chk("final_status", {busy_o, cpu_hold_o, done_o, err_o, byte_ready_o},
            ok ? 5'b00100 : 5'b01010);
        chk("final_words", words_loaded_o, n);
        @(negedge clk);
        #1;
        chk("writes_drained", exp_q.size(), 0);
    endtask

    function automatic logic [63:0] all_outs();
        return {1'b0, byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
                cpu_hold_o, busy_o, done_o, err_o, words_loaded_o};
    endfunction

    initial begin
        rst          = 1'b1;
        load_start_i = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;

        // Bytes offered in IDLE are not accepted.
        byte_valid_i = 1'b1;
        byte_i       = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("idle_not_ready", byte_ready_o, 0);
        end
        byte_valid_i = 1'b0;

        fw = '{32'h00100513, 32'h00200593};
        run_frame(32'd2, 1'b0, 8'h00, 1'b0, -1);   // good checksum
        run_frame(32'd2, 1'b1, 8'h00, 1'b0, -1);   // bad checksum -> ERR
        run_frame(32'h00001001, 1'b0, 8'h00, 1'b0, -1);
        run_frame(32'd0, 1'b0, 8'h00, 1'b0, -1);
        run_frame(32'd2, 1'b0, 8'h00, 1'b1, 5);    // gapped valid, stray start mid-DATA

        // Reset after 5 data bytes aborts the load.
        pulse_start();
        send_byte(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(fw[0][8*i +: 8], 1'b0, 1'b0);
        exp_q.push_back('{addr: 12'd0, data: fw[0], at_cyc: last_hs});
        send_byte(fw[1][7:0], 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_outputs", all_outs(), 0);
        chk("abort_writes_drained", exp_q.size(), 0);
        rst = 1'b0;
        run_frame(32'd2, 1'b0, 8'h00, 1'b0, -1);

        // Randomized frames.
        for (int f = 0; f < 5; f++) begin
            int n;
            n = $urandom_range(1, 6);
            fw.delete();
            for (int w = 0; w < n; w++) fw.push_back($urandom);
            run_frame(32'(n), $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 4 * n));
        end
        run_frame(32'h00001001 + 32'($urandom_range(0, 100000)), 1'b0, 8'h00, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
